// File: rtl/xres_reset_sequencer_if.sv
// Reset-sequencer bundle between the XRES pad stage and the core domains.
//   XRES_H_N   : pad-side external reset, active-low, asynchronous to CLK
//   SEQ_RST_N  : staged domain resets, active-low, bit 0 releases first
//   RST_DONE   : all stages released
//   GLITCH_DET : one-cycle pulse per rejected XRES_H_N level change
//   GLITCH_CNT : saturating reject count (XRES_RESET_SEQUENCER_GLITCH_CNT_EN only)
// master = sequencer side, slave = pad/consumer side.
interface xres_reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic                  XRES_H_N;
  logic [NUM_STAGES-1:0] SEQ_RST_N;
  logic                  RST_DONE;
  logic                  GLITCH_DET;
`ifdef XRES_RESET_SEQUENCER_GLITCH_CNT_EN
  logic [7:0]            GLITCH_CNT;

  modport master (input XRES_H_N, output SEQ_RST_N, output RST_DONE,
                  output GLITCH_DET, output GLITCH_CNT);
  modport slave  (output XRES_H_N, input SEQ_RST_N, input RST_DONE,
                  input GLITCH_DET, input GLITCH_CNT);
`else
  modport master (input XRES_H_N, output SEQ_RST_N, output RST_DONE,
                  output GLITCH_DET);
  modport slave  (output XRES_H_N, input SEQ_RST_N, input RST_DONE,
                  input GLITCH_DET);
`endif
endinterface

// File: rtl/xres_reset_sequencer.sv
// XRES reset sequencer: synchronises the pad-filtered XRES_H_N, applies a
// digital stability filter, then holds and releases the core domain resets
// in order, flagging pulses too short to count as a reset.
// Ports:
//   CLK   : sequencer clock
//   RESET : asynchronous active-high reset, forces all outputs asserted
//   bus   : xres_reset_sequencer_if.master (XRES_H_N in; SEQ_RST_N,
//           RST_DONE, GLITCH_DET and optional GLITCH_CNT out)
// Optional feature macro: XRES_RESET_SEQUENCER_GLITCH_CNT_EN adds the
// saturating GLITCH_CNT counter and port.
module xres_reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned STAGE_GAP     = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  xres_reset_sequencer_if.master bus
);

  localparam int unsigned FCNT_W = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GCNT_W = $clog2(STAGE_GAP + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic                   filt_n;
  logic [FCNT_W-1:0]      fcnt;
  logic                   glitch_hit_c;
  logic                   glitch_det_q;

  state_t                 state;
  logic [HCNT_W-1:0]      hcnt;
  logic [GCNT_W-1:0]      gcnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_STAGES-1:0]  seq_q;
  logic                   done_q;

  assign sync_n = sync_q[SYNC_STAGES-1];

  // A run of differing samples that ends before acceptance is a glitch.
  assign glitch_hit_c = (sync_n == filt_n) && (fcnt != '0);

  // Synchroniser chain and level-change filter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q       <= '0;
      filt_n       <= 1'b0;
      fcnt         <= '0;
      glitch_det_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.XRES_H_N};
      glitch_det_q <= glitch_hit_c;
      if (sync_n != filt_n) begin
        if (fcnt == FCNT_W'(FILTER_CYCLES - 1)) begin
          filt_n <= sync_n;
          fcnt   <= '0;
        end else begin
          fcnt <= fcnt + FCNT_W'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

`ifdef XRES_RESET_SEQUENCER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q;

  // Saturating reject counter; only RESET clears it, filtered resets do not.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      glitch_cnt_q <= '0;
    end else if (glitch_hit_c && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 8'd1;
    end
  end

  assign bus.GLITCH_CNT = glitch_cnt_q;
`endif

  // Hold / staged-release sequencer. A low filtered reset overrides every
  // state, so a stage due in the same cycle never releases.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_ASSERT;
      hcnt   <= '0;
      gcnt   <= '0;
      idx    <= '0;
      seq_q  <= '0;
      done_q <= 1'b0;
    end else if (!filt_n) begin
      state  <= ST_ASSERT;
      hcnt   <= '0;
      gcnt   <= '0;
      idx    <= '0;
      seq_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          state <= ST_HOLD;
          hcnt  <= '0;
        end
        ST_HOLD: begin
          if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
            state    <= ST_RELEASE;
            hcnt     <= '0;
            idx      <= '0;
            gcnt     <= '0;
            seq_q[0] <= 1'b1;
          end else begin
            hcnt <= hcnt + HCNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (idx == IDX_W'(NUM_STAGES - 1)) begin
            state  <= ST_DONE;
            idx    <= '0;
            gcnt   <= '0;
            seq_q  <= '1;
            done_q <= 1'b1;
          end else if (gcnt == GCNT_W'(STAGE_GAP - 1)) begin
            // Stages release in order, so the next bit is idx+1.
            idx   <= idx + IDX_W'(1);
            gcnt  <= '0;
            seq_q <= seq_q | (NUM_STAGES'(1) << (idx + IDX_W'(1)));
          end else begin
            gcnt <= gcnt + GCNT_W'(1);
          end
        end
        ST_DONE: begin
          seq_q  <= '1;
          done_q <= 1'b1;
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

  assign bus.SEQ_RST_N  = seq_q;
  assign bus.RST_DONE   = done_q;
  assign bus.GLITCH_DET = glitch_det_q;

endmodule
